// File: rtl/xm_mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port XMakina memory.
// Define XM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module xm_mem_arbiter #(
  parameter int WORD    = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic [1:0]      req_i,
  input  logic [1:0]      rw_i,
  input  logic [1:0]      byte_i,
  input  logic [WORD-1:0] adr0_i,
  input  logic [WORD-1:0] adr1_i,
  input  logic [WORD-1:0] wdata0_i,
  input  logic [WORD-1:0] wdata1_i,
  output logic [1:0]      gnt_o,
  output logic [1:0]      done_o,
  output logic [1:0]      busy_o,
  output logic            err_o,
  output logic [WORD-1:0] rdata_o,
  output logic            mem_en_o,
  output logic            mem_rw_o,
  output logic            mem_byte_o,
  output logic [WORD-1:0] mem_adr_o,
  output logic [WORD-1:0] mem_wdata_o,
  input  logic            mem_busy_i,
  input  logic [WORD-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic              win_q, win_d;
  logic              rw_q, rw_d;
  logic              byte_q, byte_d;
  logic [WORD-1:0]   adr_q, adr_d;
  logic [WORD-1:0]   wdata_q, wdata_d;
  logic [WORD-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel;

`ifdef XM_ARB_RR_EN
  logic rr_q, rr_d;
  // rr_q holds the index of the last granted port
  always_comb sel = (req_i == 2'b11) ? ~rr_q : req_i[1];
`else
  always_comb sel = ~req_i[0];
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rw_d    = rw_q;
    byte_d  = byte_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef XM_ARB_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_i != '0) begin
          win_d   = sel;
          rw_d    = rw_i[sel];
          byte_d  = byte_i[sel];
          adr_d   = sel ? adr1_i : adr0_i;
          wdata_d = sel ? wdata1_i : wdata0_i;
          state_d = S_ISSUE;
`ifdef XM_ARB_RR_EN
          rr_d    = sel;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!mem_busy_i) begin
          rdata_d = rw_q ? '0 : mem_rdata_i;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (TIMEOUT != 0 && cnt_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      rw_q    <= 1'b0;
      byte_q  <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef XM_ARB_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rw_q    <= rw_d;
      byte_q  <= byte_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef XM_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Grant is combinational in IDLE and suppressed while reset is asserted
  assign gnt_o       = (state_q == S_IDLE && req_i != '0 && !arst_i) ? {sel, ~sel} : '0;
  assign done_o      = (state_q == S_DONE) ? {win_q, ~win_q} : '0;
  assign busy_o      = req_i | ((state_q != S_IDLE) ? {win_q, ~win_q} : 2'b00);
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_en_o    = (state_q == S_ISSUE);
  assign mem_rw_o    = rw_q;
  assign mem_byte_o  = byte_q;
  assign mem_adr_o   = adr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_xm_mem_arbiter.sv
// Bench for xm_mem_arbiter: transaction table, directed corner sequences and
// randomized traffic against a cycle-index transaction model.
module tb_xm_mem_arbiter;
  localparam int W   = 16;
  localparam int TMO = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst;
  logic [1:0]    req, rw, byt;
  logic [W-1:0]  adr0, adr1, wd0, wd1, mrd;
  logic          mbusy;
  logic [1:0]    gnt, done, busy;
  logic          err, men, mrw, mbyte;
  logic [W-1:0]  rdata, madr, mwd;

  xm_mem_arbiter #(.WORD(W), .TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk_i(clk), .arst_i(arst), .req_i(req), .rw_i(rw), .byte_i(byt),
    .adr0_i(adr0), .adr1_i(adr1), .wdata0_i(wd0), .wdata1_i(wd1),
    .gnt_o(gnt), .done_o(done), .busy_o(busy), .err_o(err), .rdata_o(rdata),
    .mem_en_o(men), .mem_rw_o(mrw), .mem_byte_o(mbyte), .mem_adr_o(madr),
    .mem_wdata_o(mwd), .mem_busy_i(mbusy), .mem_rdata_i(mrd)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Transaction model: one access in flight, timed by cycle index of acceptance
  bit         m_act, m_win, m_rw, m_byte, m_err, m_rr;
  logic [W-1:0] m_adr, m_wd, m_rdata;
  int         m_t0, m_dc;

  logic [1:0]   s_gnt, s_done, s_busy;
  logic         s_men, s_mrw, s_mbyte, s_err;
  logic [W-1:0] s_madr, s_mwd, s_rdata;

  function automatic logic [1:0] oh(input bit w);
    return w ? 2'b10 : 2'b01;
  endfunction

  function automatic bit pick(input logic [1:0] r);
`ifdef XM_ARB_RR_EN
    if (r == 2'b11) return !m_rr;
`else
    if (r == 2'b11) return 1'b0;
`endif
    return r[1];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_win = 0; m_rw = 0; m_byte = 0; m_err = 0; m_rr = 0;
    m_adr = '0; m_wd = '0; m_rdata = '0; m_t0 = 0; m_dc = -1;
  endtask

  // Called at negedge with inputs set; compares, crosses one posedge, returns at negedge
  task automatic tick();
    logic [1:0] e_gnt, e_done, e_busy;
    bit e_men, w;
    #1;
    e_gnt  = (!m_act && !arst && req != 2'b00) ? oh(pick(req)) : 2'b00;
    e_men  = m_act && (cyc == m_t0 + 1);
    e_done = (m_act && cyc == m_dc) ? oh(m_win) : 2'b00;
    e_busy = req | (m_act ? oh(m_win) : 2'b00);
    chk("gnt", gnt, e_gnt);
    chk("mem_en", men, e_men);
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("err", err, m_err);
    chk("rdata", rdata, m_rdata);
    chk("mem_rw", mrw, m_rw);
    chk("mem_byte", mbyte, m_byte);
    chk("mem_adr", madr, m_adr);
    chk("mem_wdata", mwd, m_wd);
    s_gnt = gnt; s_done = done; s_busy = busy; s_men = men; s_mrw = mrw;
    s_mbyte = mbyte; s_err = err; s_madr = madr; s_mwd = mwd; s_rdata = rdata;
    @(posedge clk);
    if (arst) begin
      model_reset();
    end else if (!m_act) begin
      if (req != 2'b00) begin
        w = pick(req);
        m_act = 1; m_win = w; m_rw = rw[w]; m_byte = byt[w];
        m_adr = w ? adr1 : adr0; m_wd = w ? wd1 : wd0;
        m_t0 = cyc; m_dc = -1; m_rr = w;
      end
    end else if (cyc == m_dc) begin
      m_act = 0;
    end else if (m_dc < 0 && cyc >= m_t0 + 2) begin
      if (!mbusy) begin
        m_dc = cyc + 1; m_rdata = m_rw ? '0 : mrd; m_err = 0;
      end else if (TMO != 0 && cyc - (m_t0 + 2) == TMO - 1) begin
        m_dc = cyc + 1; m_rdata = '0; m_err = 1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]   req;
    logic         rw;
    logic         byt;
    logic [W-1:0] adr;
    logic [W-1:0] wd;
    logic [W-1:0] mrd;
    int           busy_n;
    logic [1:0]   e_gnt;
    logic [W-1:0] e_rd;
    logic         e_err;
    int           e_lat;
  } vec_t;

  vec_t vt[7];

  task automatic rand_cmd();
    rw = 2'($urandom); byt = 2'($urandom);
    adr0 = W'($urandom); adr1 = W'($urandom); wd0 = W'($urandom); wd1 = W'($urandom);
  endtask

  task automatic run_vec(input vec_t v);
    int t; bit got; int en_cnt;
    rand_cmd();
    req = v.req;
    if (v.req[0]) begin rw[0] = v.rw; byt[0] = v.byt; adr0 = v.adr; wd0 = v.wd; end
    if (v.req[1]) begin rw[1] = v.rw; byt[1] = v.byt; adr1 = v.adr; wd1 = v.wd; end
    mbusy = 1'($urandom); mrd = W'($urandom);
    tick();
    chk("vec_gnt", s_gnt, v.e_gnt);
    t = 1; got = 0; en_cnt = 0;
    while (!got && t < 40) begin
      req = 2'b00;
      rand_cmd();
      if (t >= 2) mbusy = ((t - 2) < v.busy_n);
      else        mbusy = 1'($urandom);
      mrd = mbusy ? W'($urandom) : v.mrd;
      tick();
      if (s_men) en_cnt++;
      if (t == 1) begin
        chk("vec_mem_adr", s_madr, v.adr);
        chk("vec_mem_rw", s_mrw, v.rw);
        chk("vec_mem_byte", s_mbyte, v.byt);
        chk("vec_mem_wdata", s_mwd, v.wd);
      end
      if (s_done != 2'b00) begin
        got = 1;
        chk("vec_latency", t, v.e_lat);
        chk("vec_done", s_done, v.e_gnt);
        chk("vec_rdata", s_rdata, v.e_rd);
        chk("vec_err", s_err, v.e_err);
      end
      t++;
    end
    if (!got) chk("vec_done_seen", 0, 1);
    chk("vec_mem_en_count", en_cnt, 1);
  endtask

  initial begin
    logic [1:0] cexp[4];
    int ng;

    vt[0] = '{2'b01, 1'b0, 1'b0, 16'h0100, 16'h1111, 16'hBEEF, 0,  2'b01, 16'hBEEF, 1'b0, 3};
    vt[1] = '{2'b10, 1'b1, 1'b1, 16'h2001, 16'h00A5, 16'h7777, 0,  2'b10, 16'h0000, 1'b0, 3};
    vt[2] = '{2'b01, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h5A5A, 5,  2'b01, 16'h5A5A, 1'b0, 8};
    vt[3] = '{2'b10, 1'b0, 1'b0, 16'h3FFE, 16'h0000, 16'hC3C3, 20, 2'b10, 16'h0000, 1'b1, 8};
    vt[4] = '{2'b10, 1'b0, 1'b1, 16'h0042, 16'h0000, 16'h0F0F, 1,  2'b10, 16'h0F0F, 1'b0, 4};
    vt[5] = '{2'b01, 1'b1, 1'b0, 16'hFFFF, 16'h8001, 16'h1234, 4,  2'b01, 16'h0000, 1'b0, 7};
`ifdef XM_ARB_RR_EN
    vt[6] = '{2'b11, 1'b0, 1'b0, 16'hABCD, 16'h0000, 16'h4321, 0,  2'b10, 16'h4321, 1'b0, 3};
    cexp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    vt[6] = '{2'b11, 1'b0, 1'b0, 16'hABCD, 16'h0000, 16'h4321, 0,  2'b01, 16'h4321, 1'b0, 3};
    cexp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    arst = 1; req = '0; rw = '0; byt = '0; adr0 = '0; adr1 = '0;
    wd0 = '0; wd1 = '0; mbusy = 0; mrd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick();
    arst = 0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_en", men, 0);
    chk("rst_mem_adr", madr, 0);
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Contention: both ports held high across four accesses
    req = 2'b11; rand_cmd(); mbusy = 0; mrd = W'($urandom);
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      tick();
      chk("cont_busy1", s_busy[1], 1'b1);
      if (s_gnt != 2'b00) begin
        chk("cont_gnt", s_gnt, cexp[ng]);
        ng++;
      end
    end
    chk("cont_grants", ng, 4);
    req = 2'b00;
    repeat (4) tick();

    // Reset in the middle of a DMA wait
    rand_cmd(); req = 2'b10; rw[1] = 0; mbusy = 1;
    tick();
    chk("rstw_gnt", s_gnt, 2'b10);
    req = 2'b00;
    repeat (3) tick();
    arst = 1;
    tick();
    arst = 0; mbusy = 0;
    #1;
    chk("rstw_done", done, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_mem_en", men, 0);
    chk("rstw_mem_adr", madr, 0);
    chk("rstw_err", err, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstw_no_done", s_done, 0);
    end
    req = 2'b11; rand_cmd();
    tick();
`ifdef XM_ARB_RR_EN
    chk("rstw_rr_gnt", s_gnt, 2'b10);
`else
    chk("rstw_rr_gnt", s_gnt, 2'b01);
`endif
    req = 2'b00;
    repeat (4) tick();

    // Random traffic against the model, including occasional resets
    for (int k = 0; k < 1500; k++) begin
      arst  = ($urandom_range(0, 199) == 0);
      req   = 2'($urandom);
      rand_cmd();
      mbusy = ($urandom_range(0, 3) != 0);
      mrd   = W'($urandom);
      tick();
    end
    arst = 0; req = 2'b00; mbusy = 0;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
